// File: rtl/sram_write_arb.sv
// Arbitrates SRAM write cycles between the clear engine and a FIFO of pixel writes.
// Clear strobes always win; buffered pixels drain oldest-first whenever no clear is active.
module sram_write_arb #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          clear_write,
  input  logic [ADDR_W-1:0]             clear_addr,
  input  logic                          px_valid,
  input  logic [ADDR_W-1:0]             px_addr,
  input  logic [DATA_W-1:0]             px_data,
  output logic                          px_ready,
  output logic [ADDR_W-1:0]             SRAM_ADDR,
  output logic [DATA_W-1:0]             SRAM_DQ_OUT,
  output logic                          SRAM_DQ_OE,
  output logic                          SRAM_WE_N,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          clearing
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + DATA_W;

  // CLEAR occupies bit 0 so that the clearing flag is a plain flop output.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CLEAR = 2'b01,
    DRAW  = 2'b10
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [ENT_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [LVL_W-1:0]  level_reg;

  logic [ADDR_W-1:0] sram_addr_reg;
  logic [DATA_W-1:0] sram_data_reg;
  logic              sram_oe_reg;
  logic              sram_we_n_reg;

  logic              push;
  logic              pop;
  logic [ENT_W-1:0]  head;

  assign px_ready = (level_reg != LVL_W'(FIFO_DEPTH));
  assign push     = px_valid && px_ready;
  assign head     = mem[rd_ptr_reg];

  // Decision uses the registered level, so a pixel pushed this cycle cannot
  // be popped until the next one.
  always_comb begin
    state_next = IDLE;
    if (clear_write)
      state_next = CLEAR;
    else if (level_reg != '0)
      state_next = DRAW;
  end

  assign pop = (state_next == DRAW);

  always_ff @(posedge Clk) begin
    if (push)
      mem[wr_ptr_reg] <= {px_addr, px_data};
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_reg <= level_reg + LVL_W'(1);
        2'b01:   level_reg <= level_reg - LVL_W'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg     <= IDLE;
      sram_addr_reg <= '0;
      sram_data_reg <= '0;
      sram_oe_reg   <= 1'b0;
      sram_we_n_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      case (state_next)
        CLEAR: begin
          sram_addr_reg <= clear_addr;
          sram_data_reg <= '0;
          sram_oe_reg   <= 1'b1;
          sram_we_n_reg <= 1'b0;
        end
        DRAW: begin
          sram_addr_reg <= head[ENT_W-1:DATA_W];
          sram_data_reg <= head[DATA_W-1:0];
          sram_oe_reg   <= 1'b1;
          sram_we_n_reg <= 1'b0;
        end
        default: begin
          // Address and data hold so the bus does not toggle while idle.
          sram_oe_reg   <= 1'b0;
          sram_we_n_reg <= 1'b1;
        end
      endcase
    end
  end

  assign SRAM_ADDR   = sram_addr_reg;
  assign SRAM_DQ_OUT = sram_data_reg;
  assign SRAM_DQ_OE  = sram_oe_reg;
  assign SRAM_WE_N   = sram_we_n_reg;
  assign fifo_level  = level_reg;
  assign clearing    = state_reg[0];

endmodule

// File: doc/sram_write_arb.md
SRAM_WRITE_ARB -- requirements
Module: sram_write_arb

Interface
REQ-001 Parameter ADDR_W, 20, SRAM word address width; 307200 pixels of 640x480 fit in it.
REQ-002 Parameter DATA_W, 16, SRAM data width.
REQ-003 Parameter FIFO_DEPTH, 8, pixel-write FIFO entries; power of two, minimum 2.
REQ-004 Clk  in  1  single clock; every register SHALL use the rising edge.
REQ-005 Reset  in  1  asynchronous, active-high reset.
REQ-006 clear_write  in  1  clear strobe from clear_ram; one SRAM write per high cycle, no backpressure.
REQ-007 clear_addr  in  ADDR_W  clear address from clear_ram, valid while clear_write=1.
REQ-008 px_valid  in  1  drawing-engine write request.
REQ-009 px_addr  in  ADDR_W  pixel address, qualified by px_valid.
REQ-010 px_data  in  DATA_W  pixel colour, qualified by px_valid.
REQ-011 px_ready  out  1  FIFO can accept; push occurs when px_valid & px_ready.
REQ-012 SRAM_ADDR  out  ADDR_W  registered SRAM address.
REQ-013 SRAM_DQ_OUT  out  DATA_W  registered write data.
REQ-014 SRAM_DQ_OE  out  1  drive-enable for the bidirectional DQ tri-state at top level.
REQ-015 SRAM_WE_N  out  1  registered active-low write enable.
REQ-016 fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-017 clearing  out  1  registered copy of clear_write.

Function
REQ-018 State machine SHALL have three states: IDLE (no write), CLEAR (issue clear write), DRAW (issue FIFO write). The state SHALL be re-evaluated every cycle.
REQ-019 Priority: clear_write=1 selects CLEAR regardless of FIFO contents. Otherwise a non-empty FIFO selects DRAW. Otherwise IDLE.
REQ-020 Latency SHALL be one cycle. A clear in cycle N SHALL produce SRAM_ADDR=clear_addr, SRAM_DQ_OUT=0, SRAM_WE_N=0 and SRAM_DQ_OE=1 after edge N+1.
REQ-021 In DRAW, the FIFO head SHALL be popped in the same cycle. Its addr/data SHALL appear on the SRAM outputs with SRAM_WE_N=0 and SRAM_DQ_OE=1 after the next edge.
REQ-022 In IDLE, the next edge SHALL set SRAM_WE_N=1 and SRAM_DQ_OE=0. SRAM_ADDR and SRAM_DQ_OUT SHALL hold their previous values.
REQ-023 While in CLEAR, the FIFO SHALL NOT pop. Entries SHALL be retained in order and written after the clear ends, oldest first.
REQ-024 px_ready SHALL equal (fifo_level != FIFO_DEPTH), combinationally. A push while full cannot occur.
REQ-025 Simultaneous push and pop SHALL leave fifo_level unchanged and preserve order. A push into an empty FIFO SHALL NOT be popped in the same cycle (one-cycle fall-through minimum).
REQ-026 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH. fifo_level SHALL range 0..FIFO_DEPTH.
REQ-027 At most one SRAM write SHALL be issued per cycle. Pixel writes SHALL never be lost or duplicated.
REQ-028 clearing SHALL be clear_write delayed by one cycle, aligned with the corresponding SRAM write.

Reset
REQ-029 On Reset=1, asynchronously: state=IDLE, FIFO emptied (pointers=0, fifo_level=0), SRAM_WE_N=1, SRAM_DQ_OE=0, SRAM_ADDR=0, SRAM_DQ_OUT=0, clearing=0.
REQ-030 Reset mid-clear or mid-draw SHALL abort the operation and discard all FIFO contents. No SRAM_WE_N=0 SHALL appear until one full cycle after Reset deasserts.
REQ-031 px_ready SHALL be 1 during and after reset, since the FIFO is empty.

Verification
REQ-032 Reset, then push px_addr=0x00010/px_data=0xABCD for one cycle -> after 2 edges: SRAM_ADDR=0x00010, SRAM_DQ_OUT=0xABCD, SRAM_WE_N=0 for exactly 1 cycle; fifo_level returns to 0.
REQ-033 Drive clear_write=1 with clear_addr counting 0..9 for 10 cycles -> SRAM_WE_N=0 for 10 consecutive cycles; addresses 0..9 in order; data 0; clearing matches.
REQ-034 Start the 10-cycle clear and push 3 pixels (A,B,C) during it -> all clear writes occur first, then A,B,C on three consecutive cycles; fifo_level peaks at 3.
REQ-035 Hold clear_write=1 and push 9 pixels with FIFO_DEPTH=8 -> px_ready=0 after 8 pushes; 9th accepted only after the clear ends; all 9 written in order.
REQ-036 Assert Reset while fifo_level=5 and clear active -> immediately SRAM_WE_N=1, fifo_level=0, px_ready=1; no writes of the discarded entries afterward.
REQ-037 Alternate push/pop with continuous px_valid=1 for 20 cycles -> 20 writes in order, fifo_level never exceeds 1, no gaps after the first write.
